// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word definitions for blocks that decode control_signal.
// Holds the bit index of every PC-related control bit and the default
// control word width.
package cpu_ctrl_pkg;

  localparam int CTRL_W_DEFAULT = 32;

  // Bit positions carried over from the original 8-bit PC.
  localparam int CTRL_PC_TO_MBR = 1;
  localparam int CTRL_PC_TO_MAR = 2;
  localparam int CTRL_MBR_TO_PC = 3;
  localparam int CTRL_PC_INC    = 20;

  // Bit positions added for branch, call/return and error clearing.
  localparam int CTRL_PC_BR     = 21;
  localparam int CTRL_PC_CALL   = 22;
  localparam int CTRL_PC_RET    = 23;
  localparam int CTRL_PC_ERRCLR = 24;

endpackage

// File: rtl/pc_stack_unit_ret_stack.sv
// ret_stack: LIFO of return addresses, built as a register array plus an
// entry count. The top entry sits at index count-1. A push while full and
// a pop while empty are both ignored.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (empties the stack)
//   push, din : write din as the new top entry
//   pop       : discard the top entry
//   dout      : current top entry (don't-care while empty)
//   empty     : count == 0
//   full      : count == DEPTH
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]             r_cnt;
  logic [DEPTH-1:0][W-1:0]   r_mem;
  logic [PW-1:0]             w_top;
  logic [PW-1:0]             w_wr;
  logic                      w_push;
  logic                      w_pop;

  // count-1 wraps harmlessly when empty; dout is unused in that case.
  assign w_top  = PW'(r_cnt - CW'(1));
  assign w_wr   = PW'(r_cnt);
  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == CW'(DEPTH));
  assign dout   = r_mem[w_top];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty && !w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_push) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (w_pop) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Contents need no reset; only the count defines validity.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[w_wr] <= din;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with relative branch, call/return through
// a hardware return-address stack, stall qualification and sticky stack
// error flags.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   control_signal  : control word (bits decoded via cpu_ctrl_pkg)
//   data_from_mbr   : absolute target for load and call
//   branch_offset   : two's-complement relative branch offset
//   stall           : blocks PC and stack updates (not MBR/MAR copies or clear)
//   data_to_mbr/mar : registered copies of the pre-update PC
//   pc_value        : current PC
//   stack_empty/full: decoded from the stack count
//   stack_ovf/unf   : sticky call-while-full / return-while-empty flags
module pc_stack_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int              ADDR_W      = 8,
  parameter int              CTRL_W      = CTRL_W_DEFAULT,
  parameter int              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int              INC_STEP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] control_signal,
  input  logic [ADDR_W-1:0] data_from_mbr,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              stall,
  output logic [ADDR_W-1:0] data_to_mbr,
  output logic [ADDR_W-1:0] data_to_mar,
  output logic [ADDR_W-1:0] pc_value,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_ovf,
  output logic              stack_unf
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mbr;
  logic [ADDR_W-1:0] r_mar;
  logic              r_ovf;
  logic              r_unf;

  logic              w_ret, w_call, w_load, w_br, w_inc, w_clr;
  logic              w_push, w_pop, w_ovf_set, w_unf_set;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_top;
  logic              w_empty, w_full;

  // Qualify the PC-affecting bits with stall up front so the priority
  // chain below only has to deal with live requests.
  assign w_ret  = !stall && control_signal[CTRL_PC_RET];
  assign w_call = !stall && control_signal[CTRL_PC_CALL];
  assign w_load = !stall && control_signal[CTRL_MBR_TO_PC];
  assign w_br   = !stall && control_signal[CTRL_PC_BR];
  assign w_inc  = !stall && control_signal[CTRL_PC_INC];
  assign w_clr  = control_signal[CTRL_PC_ERRCLR];

  assign w_pc_inc  = r_pc + ADDR_W'(INC_STEP);
  assign w_pop     = w_ret && !w_empty;
  assign w_unf_set = w_ret && w_empty;
  assign w_push    = !w_ret && w_call && !w_full;
  assign w_ovf_set = !w_ret && w_call && w_full;

  // Priority: return > call > load > branch > increment. The offset is
  // the same width as the PC, so a plain add is the sign-extended add
  // modulo 2^ADDR_W.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_ret) begin
      if (!w_empty) w_pc_nxt = w_top;
    end else if (w_call || w_load) begin
      w_pc_nxt = data_from_mbr;
    end else if (w_br) begin
      w_pc_nxt = r_pc + branch_offset;
    end else if (w_inc) begin
      w_pc_nxt = w_pc_inc;
    end
  end

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_inc),
    .dout  (w_top),
    .empty (w_empty),
    .full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_ADDR;
      r_mbr <= '0;
      r_mar <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (control_signal[CTRL_PC_TO_MBR]) r_mbr <= r_pc;
      if (control_signal[CTRL_PC_TO_MAR]) r_mar <= r_pc;
      // A new error in the same cycle as a clear leaves the flag set.
      if (w_ovf_set)  r_ovf <= 1'b1;
      else if (w_clr) r_ovf <= 1'b0;
      if (w_unf_set)  r_unf <= 1'b1;
      else if (w_clr) r_unf <= 1'b0;
    end
  end

  assign pc_value    = r_pc;
  assign data_to_mbr = r_mbr;
  assign data_to_mar = r_mar;
  assign stack_empty = w_empty;
  assign stack_full  = w_full;
  assign stack_ovf   = r_ovf;
  assign stack_unf   = r_unf;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl;
  logic [7:0]  din, off;
  logic        stall;
  logic [7:0]  mbr_o, mar_o, pc_o;
  logic        empty_o, full_o, ovf_o, unf_o;

  int total = 0;
  int bad   = 0;

  pc_stack_unit dut (
    .clk(clk), .rst(rst), .control_signal(ctrl), .data_from_mbr(din),
    .branch_offset(off), .stall(stall), .data_to_mbr(mbr_o),
    .data_to_mar(mar_o), .pc_value(pc_o), .stack_empty(empty_o),
    .stack_full(full_o), .stack_ovf(ovf_o), .stack_unf(unf_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] b(input int n);
    logic [31:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply current inputs across one rising edge; outputs are then sampled
  // 1ns later, well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags();
    return {empty_o, full_o, ovf_o, unf_o};
  endfunction

  task automatic drive(input logic [31:0] c, input logic [7:0] d, input logic [7:0] o, input logic s);
    ctrl = c; din = d; off = o; stall = s;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_pc, m_mbr, m_mar;
  logic [7:0] m_stk[$];
  logic       m_ovf, m_unf;

  task automatic model_step(input logic r, input logic [31:0] c, input logic [7:0] d,
                            input logic [7:0] o, input logic s);
    logic [7:0] old_pc;
    old_pc = m_pc;
    if (r) begin
      m_pc = 8'h00; m_mbr = 8'h00; m_mar = 8'h00;
      m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    if (c[CTRL_PC_TO_MBR]) m_mbr = old_pc;
    if (c[CTRL_PC_TO_MAR]) m_mar = old_pc;
    if (c[CTRL_PC_ERRCLR]) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (!s) begin
      if (c[CTRL_PC_RET]) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else m_unf = 1'b1;
      end else if (c[CTRL_PC_CALL]) begin
        if (m_stk.size() < 4) m_stk.push_back(8'((int'(old_pc) + 1) % 256));
        else m_ovf = 1'b1;
        m_pc = d;
      end else if (c[CTRL_MBR_TO_PC]) begin
        m_pc = d;
      end else if (c[CTRL_PC_BR]) begin
        m_pc = 8'((int'(old_pc) + int'($signed(o)) + 256) % 256);
      end else if (c[CTRL_PC_INC]) begin
        m_pc = 8'((int'(old_pc) + 1) % 256);
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] c;
    logic [7:0]  d;
    logic [7:0]  o;
    logic        s;
    logic [7:0]  e_pc;
    logic [7:0]  e_mbr;
    logic [7:0]  e_mar;
    logic [3:0]  e_flg;   // {empty, full, ovf, unf}
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    drive('0, 8'h00, 8'h00, 1'b0);
    step();
    check("reset_pc", pc_o, 8'h00);
    check("reset_mbr", mbr_o, 8'h00);
    check("reset_mar", mar_o, 8'h00);
    check("reset_flags", flags(), 4'b1000);
    rst = 1'b0;

    tbl.push_back('{b(3),                 8'h10, 8'h00, 0, 8'h10, 8'h00, 8'h00, 4'b1000});
    tbl.push_back('{b(3)|b(20)|b(2),      8'h40, 8'h00, 0, 8'h40, 8'h00, 8'h10, 4'b1000});
    tbl.push_back('{b(3),                 8'h05, 8'h00, 0, 8'h05, 8'h00, 8'h10, 4'b1000});
    tbl.push_back('{b(21),                8'h00, 8'hFD, 0, 8'h02, 8'h00, 8'h10, 4'b1000});
    tbl.push_back('{b(3),                 8'hFE, 8'h00, 0, 8'hFE, 8'h00, 8'h10, 4'b1000});
    tbl.push_back('{b(21),                8'h00, 8'h04, 0, 8'h02, 8'h00, 8'h10, 4'b1000});
    tbl.push_back('{b(3),                 8'h20, 8'h00, 0, 8'h20, 8'h00, 8'h10, 4'b1000});
    tbl.push_back('{b(22),                8'h50, 8'h00, 0, 8'h50, 8'h00, 8'h10, 4'b0000});
    tbl.push_back('{b(22)|b(3),           8'h70, 8'h00, 0, 8'h70, 8'h00, 8'h10, 4'b0000});
    tbl.push_back('{b(23)|b(22)|b(1),     8'h99, 8'h00, 0, 8'h51, 8'h70, 8'h10, 4'b0000});
    tbl.push_back('{b(23),                8'h00, 8'h00, 0, 8'h21, 8'h70, 8'h10, 4'b1000});
    tbl.push_back('{b(23),                8'h00, 8'h00, 0, 8'h21, 8'h70, 8'h10, 4'b1001});
    tbl.push_back('{b(24),                8'h00, 8'h00, 0, 8'h21, 8'h70, 8'h10, 4'b1000});
    tbl.push_back('{b(20),                8'h00, 8'h00, 0, 8'h22, 8'h70, 8'h10, 4'b1000});
    tbl.push_back('{b(22)|b(1),           8'h99, 8'h00, 1, 8'h22, 8'h22, 8'h10, 4'b1000});
    tbl.push_back('{b(23)|b(24),          8'h00, 8'h00, 0, 8'h22, 8'h22, 8'h10, 4'b1001});
    tbl.push_back('{b(24),                8'h00, 8'h00, 1, 8'h22, 8'h22, 8'h10, 4'b1000});

    foreach (tbl[i]) begin
      drive(tbl[i].c, tbl[i].d, tbl[i].o, tbl[i].s);
      step();
      check($sformatf("vec%0d_pc", i), pc_o, tbl[i].e_pc);
      check($sformatf("vec%0d_mbr", i), mbr_o, tbl[i].e_mbr);
      check($sformatf("vec%0d_mar", i), mar_o, tbl[i].e_mar);
      check($sformatf("vec%0d_flags", i), flags(), tbl[i].e_flg);
    end

    // Reset then 256 increments: PC wraps back to 0.
    rst = 1'b1; drive('0, 8'h00, 8'h00, 1'b0); step(); rst = 1'b0;
    drive(b(20), 8'h00, 8'h00, 1'b0);
    for (int k = 1; k <= 256; k++) begin
      step();
      if (k == 255) check("inc_ff", pc_o, 8'hFF);
      if (k == 256) check("inc_wrap", pc_o, 8'h00);
    end

    // Overflow / underflow from PC=0.
    rst = 1'b1; drive('0, 8'h00, 8'h00, 1'b0); step(); rst = 1'b0;
    drive(b(22), 8'h11, 8'h00, 1'b0); step();
    drive(b(22), 8'h22, 8'h00, 1'b0); step();
    drive(b(22), 8'h33, 8'h00, 1'b0); step();
    drive(b(22), 8'h44, 8'h00, 1'b0); step();
    check("fill_full", flags(), 4'b0100);
    drive(b(22), 8'hA0, 8'h00, 1'b0); step();
    check("ovf_pc", pc_o, 8'hA0);
    check("ovf_flags", flags(), 4'b0110);
    drive(b(23), 8'h00, 8'h00, 1'b0); step(); check("pop1", pc_o, 8'h34);
    step(); check("pop2", pc_o, 8'h23);
    step(); check("pop3", pc_o, 8'h12);
    step(); check("pop4", pc_o, 8'h01);
    step();
    check("unf_pc", pc_o, 8'h01);
    check("unf_flags", flags(), 4'b1011);
    drive(b(24), 8'h00, 8'h00, 1'b0); step();
    check("errclr", flags(), 4'b1000);

    // Reset during a call with a non-empty stack.
    drive(b(22), 8'h40, 8'h00, 1'b0); step();
    check("pre_rst_call", flags(), 4'b0000);
    rst = 1'b1; drive(b(22), 8'h60, 8'h00, 1'b0); step(); rst = 1'b0;
    check("midop_rst_pc", pc_o, 8'h00);
    check("midop_rst_flags", flags(), 4'b1000);

    // Randomised run against the reference model.
    drive('0, 8'h00, 8'h00, 1'b0);
    model_step(1'b1, '0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] c;
      logic        r, s;
      int          bits[9];
      bits = '{1, 2, 3, 20, 21, 22, 23, 24, 0};
      c = '0;
      for (int j = 0; j < 8; j++) if ($urandom_range(0, 99) < 25) c[bits[j]] = 1'b1;
      c[$urandom_range(0, 31)] ^= ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 4) == 0);
      drive(c, 8'($urandom), 8'($urandom), s);
      rst = r;
      model_step(r, c, din, off, s);
      step();
      rst = 1'b0;
      check("rnd_pc", pc_o, m_pc);
      check("rnd_mbr", mbr_o, m_mbr);
      check("rnd_mar", mar_o, m_mar);
      check("rnd_flags", flags(), {m_stk.size() == 0, m_stk.size() == 4, m_ovf, m_unf});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised program-counter unit, the next generation of the 8-bit PC. It keeps the existing control-word bit positions for increment, load from MBR, and drive to MBR/MAR. It adds relative branching, call/return through a hardware return-address stack, a stall qualifier, and sticky stack-error flags. It sits between the control unit (control_signal) and the MBR/MAR registers.

Parameters:
ADDR_W, 8, PC / address width in bits
CTRL_W, 32, control word width
STACK_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_ADDR, 0, PC value after reset
INC_STEP, 1, amount added by increment and pushed by call

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
control_signal  in  CTRL_W  control word; bits used listed under Behaviour
data_from_mbr  in  ADDR_W  absolute target for load/call
branch_offset  in  ADDR_W  two's-complement offset for relative branch
stall  in  1  when 1, blocks all PC and stack updates this cycle
data_to_mbr  out  ADDR_W  registered PC copy toward MBR
data_to_mar  out  ADDR_W  registered PC copy toward MAR
pc_value  out  ADDR_W  current PC, direct from register
stack_empty  out  1  stack holds 0 entries
stack_full  out  1  stack holds STACK_DEPTH entries
stack_ovf  out  1  sticky: call attempted while full
stack_unf  out  1  sticky: return attempted while empty

Behaviour:
- Reset is synchronous (rst=1 at posedge clk) and overrides everything.
  - pc=RESET_ADDR, data_to_mbr=0, data_to_mar=0.
  - Stack count=0, so stack_empty=1 and stack_full=0.
  - stack_ovf=0, stack_unf=0. Stack contents are don't-care.
- Control bits:
  - [1] PC->MBR
  - [2] PC->MAR
  - [3] load PC from data_from_mbr
  - [20] increment
  - [21] relative branch
  - [22] call
  - [23] return
  - [24] clear error flags
- Bits [1] and [2] capture the pre-update PC, so the new value is visible one cycle later. Both bits ignore stall. Each output holds its value when its bit is 0.
- PC update runs only when stall=0. Exactly one action occurs per cycle, chosen by priority return > call > load > branch > increment.
  - return: if count>0, pc=top entry and the entry is popped. If count=0, PC is unchanged and stack_unf is set.
  - call: if count<STACK_DEPTH, push (pc+INC_STEP) and set pc=data_from_mbr. If the stack is full, pc=data_from_mbr still happens, the stack is unchanged, and stack_ovf is set.
  - load: pc=data_from_mbr.
  - branch: pc=pc+branch_offset, with the offset sign-extended. The result wraps modulo 2^ADDR_W.
  - increment: pc=pc+INC_STEP, wrapping modulo 2^ADDR_W (e.g. 8'hFF -> 8'h00).
  - No bit set: PC holds.
- Lower-priority bits asserted in the same cycle are ignored. Example: [3] and [20] together means load only. This intentionally differs from the old block, where ordering of assignments decided the winner.
- Bit [24] clears stack_ovf/stack_unf; this ignores stall. If a new error occurs in the same cycle, the set wins.
- Stall=1 with [22]/[23] set: no push/pop and no error flags.
- Stack is LIFO, implemented as a pointer plus register array. The top entry is at index count-1.
- stack_full and stack_empty are decoded from the registered count (no extra latency).
- Reset asserted mid-call/return: reset wins and the stack is emptied.

Decomposition:
- Shared package cpu_ctrl_pkg holds the control bit index constants.
  - Existing: CTRL_PC_TO_MBR=1, CTRL_PC_TO_MAR=2, CTRL_MBR_TO_PC=3, CTRL_PC_INC=20.
  - New: CTRL_PC_BR=21, CTRL_PC_CALL=22, CTRL_PC_RET=23, CTRL_PC_ERRCLR=24.
  - Also holds CTRL_W default. Other blocks decoding the control word use the same constants.
- One natural sub-module: ret_stack (parameters DEPTH and W). Ports: push, pop, din, dout, empty, full, plus sync reset. It ignores push-when-full and pop-when-empty.
- Overflow/underflow flags and priority decode stay in pc_stack_unit.

Test Plan:
- Reset/increment: rst=1 for one cycle, then [20] for 256 cycles (ADDR_W=8) -> pc wraps to 0 at cycle 256; data_to_mbr=0 and data_to_mar=0 after reset.
- Load vs increment: pc=8'h10, [3]+[20], data_from_mbr=8'h40 -> pc=8'h40 next cycle. With [2] also set that cycle, data_to_mar=8'h10 (old PC).
- Branch: pc=8'h05, [21], branch_offset=8'hFD -> pc=8'h02. Then pc=8'hFE, offset=8'h04 -> pc=8'h02 (wrap).
- Call/return nesting: pc=8'h20, call to 8'h50, then call to 8'h70, then two returns -> pc sequence 50,70,51,21; stack_empty=1 at end.
- Overflow/underflow: fill the stack with 4 calls, then a 5th call to 8'hA0 -> pc=8'hA0, stack_ovf=1, stack_full=1. Pop 4 times, then a 5th return -> pc unchanged, stack_unf=1. Then [24] -> both flags 0.
- Stall and mid-op reset: stall=1 with [22] -> pc, count and flags unchanged, but [1] still updates data_to_mbr. Then rst=1 during a call cycle -> pc=RESET_ADDR and stack_empty=1.
